// File: rtl/job_dispatcher.sv
// Job dispatcher: buffers tagged requests, starts one worker job at a time and
// returns a completion record per job, ended either by the worker or a watchdog.
module job_dispatcher #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [TAG_W-1:0]               req_tag_i,
  output logic                           start_o,
  input  logic                           worker_busy_i,
  input  logic                           worker_done_i,
  output logic                           cpl_valid_o,
  input  logic                           cpl_ready_i,
  output logic [TAG_W-1:0]               cpl_tag_o,
  output logic                           cpl_timeout_o,
  output logic [$clog2(DEPTH+1)-1:0]     pending_o,
  output logic                           idle_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CPL
  } state_t;

  state_t             state;
  logic [TAG_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [WD_W-1:0]    wdog;
  logic [TAG_W-1:0]   job_tag;
  logic               push;
  logic               pop;

  assign req_ready_o = (count != CNT_W'(DEPTH));
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state == S_IDLE) && (count != '0) && !worker_busy_i && !worker_done_i;
  assign pending_o   = count;
  assign idle_o      = (state == S_IDLE) && (count == '0);

  // Storage is not reset; only pointers and occupancy define its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= req_tag_i;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // job_tag holds the in-flight tag; cpl_tag_o is loaded only when the job
  // ends, so it keeps the previous completion's value while the next job runs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      wdog          <= '0;
      job_tag       <= '0;
      start_o       <= 1'b0;
      cpl_valid_o   <= 1'b0;
      cpl_tag_o     <= '0;
      cpl_timeout_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            job_tag <= mem[rd_ptr];
            wdog    <= '0;
            start_o <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (worker_done_i) begin
            cpl_tag_o     <= job_tag;
            cpl_timeout_o <= 1'b0;
            cpl_valid_o   <= 1'b1;
            state         <= S_CPL;
          end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            cpl_tag_o     <= job_tag;
            cpl_timeout_o <= 1'b1;
            cpl_valid_o   <= 1'b1;
            state         <= S_CPL;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_CPL: begin
          if (cpl_ready_i) begin
            cpl_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          wdog        <= '0;
          cpl_valid_o <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher: instance 0 uses the default watchdog,
// instance 1 a 4-cycle watchdog; each has its own worker model and scoreboard.
module tb_job_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv    [2];
  logic [3:0] rtag  [2];
  logic       rrdy  [2];
  logic       st    [2];
  logic       wbusy [2];
  logic       stall [2];
  logic       cv    [2];
  logic       cr    [2];
  logic [3:0] ctag  [2];
  logic       cto   [2];
  logic [2:0] pend  [2];
  logic       idl   [2];

  logic       wm    [2] = '{1'b0, 1'b0};
  logic       wdone [2] = '{1'b0, 1'b0};
  logic       wact  [2] = '{1'b0, 1'b0};
  int         wlen  [2];
  int         wcnt  [2];

  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign wbusy[0] = wm[0] | stall[0];
  assign wbusy[1] = wm[1] | stall[1];

  job_dispatcher #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv[0]), .req_ready_o(rrdy[0]),
    .req_tag_i(rtag[0]), .start_o(st[0]), .worker_busy_i(wbusy[0]),
    .worker_done_i(wdone[0]), .cpl_valid_o(cv[0]), .cpl_ready_i(cr[0]),
    .cpl_tag_o(ctag[0]), .cpl_timeout_o(cto[0]), .pending_o(pend[0]),
    .idle_o(idl[0])
  );

  job_dispatcher #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYCLES(4)) u_dut_to (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv[1]), .req_ready_o(rrdy[1]),
    .req_tag_i(rtag[1]), .start_o(st[1]), .worker_busy_i(wbusy[1]),
    .worker_done_i(wdone[1]), .cpl_valid_o(cv[1]), .cpl_ready_i(cr[1]),
    .cpl_tag_o(ctag[1]), .cpl_timeout_o(cto[1]), .pending_o(pend[1]),
    .idle_o(idl[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Worker: after start, wlen busy cycles then a one-cycle done with busy low.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      wdone[i] = 1'b0;
      if (st[i]) begin
        wact[i] = 1'b1;
        wcnt[i] = wlen[i];
      end else if (wact[i]) begin
        if (wcnt[i] > 0) begin
          wm[i]   = 1'b1;
          wcnt[i] = wcnt[i] - 1;
        end else begin
          wm[i]    = 1'b0;
          wdone[i] = 1'b1;
          wact[i]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard: each completion handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    logic [4:0] e;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!rst && cv[i] && cr[i]) begin
        if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          chk($sformatf("cpl_unexpected[%0d]", i), 0, 1);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("cpl_tag[%0d]", i), ctag[i], e[3:0]);
          chk($sformatf("cpl_timeout[%0d]", i), cto[i], e[4]);
        end
      end
    end
  end

  task automatic drain(input int i, input string tag);
    int g;
    for (g = 0; g < 300; g++) begin
      if (idl[i] && (i == 0 ? exp_q0.size() : exp_q1.size()) == 0) break;
      step();
    end
    chk(tag, (g < 300), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "bench stopped");
  end

  initial begin
    int g;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rtag[i] = '0; cr[i] = 1'b1; stall[i] = 1'b0; wlen[i] = 5;
    end
    step(2);
    chk("rst_start", st[0], 0);
    chk("rst_cpl_valid", cv[0], 0);
    chk("rst_cpl_tag", ctag[0], 0);
    chk("rst_cpl_timeout", cto[0], 0);
    chk("rst_pending", pend[0], 0);
    chk("rst_ready", rrdy[0], 1);
    chk("rst_idle", idl[0], 1);
    rst = 1'b0;
    step();

    // Single job, cycle 0 = push.
    rv[0] = 1'b1; rtag[0] = 4'h3; exp_q0.push_back({1'b0, 4'h3});
    step(); rv[0] = 1'b0;
    chk("single_pend_c1", pend[0], 1);
    chk("single_start_c1", st[0], 0);
    step(); chk("single_start_c2", st[0], 1);
    step(); chk("single_start_c3", st[0], 0);
    step(5); chk("single_cv_c8", cv[0], 0);
    step();
    chk("single_cv_c9", cv[0], 1);
    chk("single_tag_c9", ctag[0], 4'h3);
    chk("single_to_c9", cto[0], 0);
    step();
    chk("single_idle_c10", idl[0], 1);
    chk("single_cv_c10", cv[0], 0);

    // Fill and back-pressure.
    wlen[0] = 2; stall[0] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      rv[0] = 1'b1; rtag[0] = 4'(t);
      for (g = 0; g < 50 && !rrdy[0]; g++) begin
        if (g == 0) begin
          chk("full_ready", rrdy[0], 0);
          chk("full_pend", pend[0], 4);
          stall[0] = 1'b0;
        end
        step();
      end
      chk("accept_bound", (g < 50), 1);
      if (t == 5) chk("tag5_after_pop_pend", pend[0], 3);
      exp_q0.push_back({1'b0, 4'(t)});
      step();
    end
    rv[0] = 1'b0;
    drain(0, "fill_drain");

    // Simultaneous push/pop across pointer wrap.
    stall[0] = 1'b1;
    rv[0] = 1'b1; rtag[0] = 4'h6; exp_q0.push_back({1'b0, 4'h6}); step();
    rtag[0] = 4'h7; exp_q0.push_back({1'b0, 4'h7}); step();
    chk("pp_pend_before", pend[0], 2);
    rtag[0] = 4'h8; exp_q0.push_back({1'b0, 4'h8}); stall[0] = 1'b0;
    step(); rv[0] = 1'b0;
    chk("pp_pend_after", pend[0], 2);
    chk("pp_start", st[0], 1);
    drain(0, "pp_drain");

    // Watchdog timeout on the 4-cycle instance, cycle 0 = push of 0xA.
    wlen[1] = 5;
    rv[1] = 1'b1; rtag[1] = 4'hA; exp_q1.push_back({1'b1, 4'hA}); step();
    rtag[1] = 4'hB; exp_q1.push_back({1'b1, 4'hB}); step();
    rv[1] = 1'b0;
    chk("to_start_c2", st[1], 1);
    step(4); chk("to_cv_c6", cv[1], 0);
    step();
    chk("to_cv_c7", cv[1], 1);
    chk("to_flag_c7", cto[1], 1);
    chk("to_tag_c7", ctag[1], 4'hA);
    step();
    chk("to_cv_c8", cv[1], 0);
    chk("to_start_c8", st[1], 0);
    step();
    chk("to_start_c9", st[1], 0);
    chk("to_pend_c9", pend[1], 1);
    step(); chk("to_start_c10", st[1], 1);
    drain(1, "to_drain");

    // Completion back-pressure.
    wlen[0] = 2; cr[0] = 1'b0;
    rv[0] = 1'b1; rtag[0] = 4'hC; exp_q0.push_back({1'b0, 4'hC}); step();
    rtag[0] = 4'hD; exp_q0.push_back({1'b0, 4'hD}); step();
    rv[0] = 1'b0;
    for (g = 0; g < 50 && !cv[0]; g++) step();
    chk("bp_cv_bound", (g < 50), 1);
    for (int k = 0; k < 4; k++) begin
      chk("bp_cv", cv[0], 1);
      chk("bp_tag", ctag[0], 4'hC);
      chk("bp_to", cto[0], 0);
      chk("bp_no_start", st[0], 0);
      chk("bp_pend", pend[0], 1);
      if (k == 3) cr[0] = 1'b1;
      else step();
    end
    drain(0, "bp_drain");

    // Mid-run reset in S_WAIT with two jobs queued; no completions expected.
    wlen[0] = 10;
    rv[0] = 1'b1; rtag[0] = 4'hE; step();
    rtag[0] = 4'hF; step();
    rtag[0] = 4'h1; step();
    rv[0] = 1'b0;
    chk("mr_pend_before", pend[0], 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_pend", pend[0], 0);
    chk("mr_cv", cv[0], 0);
    chk("mr_start", st[0], 0);
    chk("mr_idle", idl[0], 1);
    step(15);
    chk("mr_idle_late", idl[0], 1);
    chk("mr_cv_late", cv[0], 0);
    chk("sb_empty0", exp_q0.size(), 0);
    chk("sb_empty1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Upstream feeder for the fixed-latency worker FSM (start/busy/done pulse interface).
- Buffers tagged job requests in a small FIFO, issues one start pulse per job, and waits for the worker's done pulse or a watchdog timeout.
- Returns one completion record per job on a valid/ready port.
- Sits between the command front-end and a single worker instance.

Parameters:
- DEPTH, 4: request FIFO entries. Power of two, >= 2.
- TAG_W, 4: job tag width.
- TIMEOUT_CYCLES, 16: maximum cycles spent in S_WAIT before the timeout is declared. Must be >= 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; equals !full.
- req_tag_i  in  TAG_W  request tag.
- start_o  out  1  one-cycle start pulse to the worker.
- worker_busy_i  in  1  worker busy indication.
- worker_done_i  in  1  worker one-cycle done pulse.
- cpl_valid_o  out  1  completion valid.
- cpl_ready_i  in  1  completion ready.
- cpl_tag_o  out  TAG_W  tag of the completed job.
- cpl_timeout_o  out  1  1 = job ended by watchdog, 0 = worker done.
- pending_o  out  $clog2(DEPTH+1)  FIFO occupancy.
- idle_o  out  1  high when state is S_IDLE and pending_o == 0.

Behaviour:
- Reset (rst_i high at an edge): state S_IDLE, FIFO empty, watchdog 0, tag register 0. Outputs after reset: start_o=0, cpl_valid_o=0, cpl_tag_o=0, cpl_timeout_o=0, pending_o=0, req_ready_o=1, idle_o=1.
- Reset mid-operation drops all queued and in-flight jobs. No completion is emitted for them.
- FIFO push: occurs when req_valid_i && req_ready_o.
- FIFO pop: occurs only on the S_IDLE dispatch. Push and pop in the same cycle leave pending_o unchanged.
- No push when full: req_ready_o=0 and no bypass path. Pointers wrap modulo DEPTH.
- States: S_IDLE, S_START, S_WAIT, S_CPL.
- S_IDLE transition:
  - Condition: pending_o > 0 && !worker_busy_i && !worker_done_i.
  - Actions: pop the head, latch its tag, clear the watchdog, go to S_START.
  - While the worker is still busy (e.g. after a timeout), dispatch stalls.
- S_START: start_o=1 for exactly this cycle. Next state is S_WAIT unconditionally.
- S_WAIT:
  - worker_done_i=1: go to S_CPL with timeout flag 0.
  - Else, watchdog == TIMEOUT_CYCLES-1: go to S_CPL with timeout flag 1.
  - Else: watchdog increments.
  - done has priority when both events fall in the same cycle.
  - Watchdog width is $clog2(TIMEOUT_CYCLES+1). The increment is width-matched and never wraps.
- S_CPL:
  - cpl_valid_o=1. cpl_tag_o and cpl_timeout_o are held stable until the handshake.
  - On cpl_ready_i go to S_IDLE. Otherwise hold.
  - cpl_tag_o and cpl_timeout_o keep their last values outside S_CPL.
- worker_done_i outside S_WAIT (late done after a timeout) is ignored. It produces no completion and no state change.
- Latency: push at cycle T into an empty FIFO with an idle worker gives pending_o=1 at T+1, dispatch at T+1, and start_o at T+2. The completion appears the cycle after done is sampled.
- Illegal state encoding: go to S_IDLE and clear the watchdog. The FIFO is untouched.
- All outputs are decoded from registered state. There is no combinational path from any input to start_o or cpl_valid_o. req_ready_o depends only on the occupancy register.

Test Plan:
- Single job:
  - Stimulus: push tag 0x3 at cycle 0; worker modelled as 5 busy cycles then a done pulse; cpl_ready_i=1.
  - Required: start_o at cycle 2, done at cycle 8, cpl_valid_o at cycle 9 with tag 0x3 and timeout 0, idle_o=1 at cycle 10.
- Fill and back-pressure:
  - Stimulus: push tags 1..5 on consecutive cycles with the worker stalled busy.
  - Required: req_ready_o=0 once pending_o=4. Tag 5 accepted only after the first pop. Completions in order 1,2,3,4,5.
- Simultaneous push/pop:
  - Stimulus: pending_o=2 and a push in the dispatch cycle.
  - Required: pending_o stays 2. FIFO order is preserved across pointer wrap.
- Timeout (TIMEOUT_CYCLES=4):
  - Stimulus: worker with 5 busy cycles.
  - Required: cpl_timeout_o=1 after 4 S_WAIT cycles. The late done is ignored. The next start_o is delayed until worker_busy_i and worker_done_i are both low.
- Completion back-pressure:
  - Stimulus: cpl_ready_i=0 for 3 cycles in S_CPL.
  - Required: cpl_valid_o, cpl_tag_o and cpl_timeout_o are stable, and no new start_o is issued.
- Mid-run reset:
  - Stimulus: rst_i=1 for 1 cycle while in S_WAIT with pending_o=2.
  - Required: next cycle pending_o=0, cpl_valid_o=0, start_o=0, idle_o=1. No completion for the dropped jobs.
